// File: rtl/tick_pkg.sv
// Shared encodings and elaboration-time helpers for the tick scheduler.
package tick_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_APPLY = 1'b1;

  // Integer division truncates; 0 marks an unusable frequency ratio.
  function automatic int unsigned calc_prescale(input int unsigned freq_in,
                                                input int unsigned tick_freq);
    if (tick_freq == 32'd0) begin
      return 32'd0;
    end else begin
      return freq_in / tick_freq;
    end
  endfunction

  function automatic int unsigned presc_width(input int unsigned prescale);
    return $clog2(prescale) + 32'd1;
  endfunction

  function automatic int unsigned chan_idx_width(input int unsigned channels);
    return $clog2(channels) + 32'd1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: period/enable registers and a base-tick counter
// that emits a registered one-cycle pulse when the period expires.
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    strobe_i,
  input  logic                    write_i,
  input  logic                    clear_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    enable_i,
  output logic                    pulse_o,
  output logic                    active_o
);

  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic                    pulse_q, pulse_d;

  // A clear in the strobe cycle wins, so a freshly written channel skips that tick.
  always_comb begin
    period_d = period_q;
    en_d     = en_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (write_i) begin
      period_d = period_i;
      en_d     = enable_i && (period_i != {PERIOD_WIDTH{1'b0}});
    end else begin
      en_d     = en_q;
    end
    if (clear_i) begin
      cnt_d = {PERIOD_WIDTH{1'b0}};
    end else if (strobe_i && en_q && (period_q != {PERIOD_WIDTH{1'b0}})) begin
      if (cnt_q == (period_q - PERIOD_WIDTH'(1'b1))) begin
        cnt_d   = {PERIOD_WIDTH{1'b0}};
        pulse_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + PERIOD_WIDTH'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      period_q <= {PERIOD_WIDTH{1'b0}};
      cnt_q    <= {PERIOD_WIDTH{1'b0}};
      en_q     <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o  = pulse_q;
  assign active_o = en_q;

endmodule

// File: rtl/tick_scheduler.sv
// Periodic event scheduler: one shared prescaler feeding CHANNELS period
// counters, programmed through a two-cycle valid/ready config port.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int unsigned FREQUENCY_IN   = 50_000_000,
  parameter int unsigned TICK_FREQUENCY = 1_000,
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned PERIOD_WIDTH   = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       CfgValid,
  output logic                       CfgReady,
  input  logic [$clog2(CHANNELS):0]  CfgChannel,
  input  logic [PERIOD_WIDTH-1:0]    CfgPeriod,
  input  logic                       CfgEnable,
  output logic                       BaseTick,
  output logic [CHANNELS-1:0]        ChannelPulse,
  output logic [CHANNELS-1:0]        ChannelActive
);

  localparam int unsigned PRESCALE = calc_prescale(FREQUENCY_IN, TICK_FREQUENCY);
  localparam int unsigned PS_W     = presc_width(PRESCALE);
  localparam int unsigned CH_W     = chan_idx_width(CHANNELS);

  if (PRESCALE < 32'd1) begin : g_freq_check
    $error("_ERROR_FREQ_TOO_HIGH_");
  end

  logic [PS_W-1:0]         presc_q, presc_d;
  logic                    strobe_s;
  logic                    base_tick_q;
  logic [0:0]              state_q, state_d;
  logic                    ready_q, ready_d;
  logic [CH_W-1:0]         cfg_ch_q, cfg_ch_d;
  logic [PERIOD_WIDTH-1:0] cfg_period_q, cfg_period_d;
  logic                    cfg_en_q, cfg_en_d;
  logic                    accept_s;
  logic                    apply_s;

  assign strobe_s = (presc_q == PS_W'(PRESCALE - 32'd1));
  assign accept_s = CfgValid && ready_q;
  assign apply_s  = (state_q == ST_APPLY);

  // Ready is registered from the next state so it stays low through reset
  // and the first cycle after release.
  always_comb begin
    presc_d      = strobe_s ? {PS_W{1'b0}} : (presc_q + PS_W'(1'b1));
    state_d      = state_q;
    cfg_ch_d     = cfg_ch_q;
    cfg_period_d = cfg_period_q;
    cfg_en_d     = cfg_en_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_APPLY;
          cfg_ch_d     = CfgChannel;
          cfg_period_d = CfgPeriod;
          cfg_en_d     = CfgEnable;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q      <= {PS_W{1'b0}};
      base_tick_q  <= 1'b0;
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      cfg_ch_q     <= {CH_W{1'b0}};
      cfg_period_q <= {PERIOD_WIDTH{1'b0}};
      cfg_en_q     <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      base_tick_q  <= strobe_s;
      state_q      <= state_d;
      ready_q      <= ready_d;
      cfg_ch_q     <= cfg_ch_d;
      cfg_period_q <= cfg_period_d;
      cfg_en_q     <= cfg_en_d;
    end
  end

  // Out-of-range channel indices match no instance, so APPLY is a no-op for them.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic write_s;
    assign write_s = apply_s && (cfg_ch_q == CH_W'(i));
    tick_channel #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_chan (
      .clk_i    (Clk),
      .reset_i  (Reset),
      .strobe_i (strobe_s),
      .write_i  (write_s),
      .clear_i  (write_s),
      .period_i (cfg_period_q),
      .enable_i (cfg_en_q),
      .pulse_o  (ChannelPulse[i]),
      .active_o (ChannelActive[i])
    );
  end

  assign CfgReady = ready_q;
  assign BaseTick = base_tick_q;

endmodule
